// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter in front of a single mem_cache port.
// Each grant holds the strobes for ACCESS_CYCLES cycles, then acks the winner for one cycle.
module cache_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              last_grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // On a tie the port that did not complete last wins.
    win      = (req0 & req1) ? ~last_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          cnt_d   = 4'(ACCESS_CYCLES - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_q) rdata1_d = mem_rdata;
            else       rdata0_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign mem_read   = (state_q == ACCESS) & ~we_q;
  assign mem_write  = (state_q == ACCESS) &  we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ack0       = (state_q == DONE) & ~gnt_q;
  assign ack1       = (state_q == DONE) &  gnt_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign last_grant = last_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: vector table, random transactions against a
// transaction-level model, and hand sequences for round-robin, reset abort and ACCESS_CYCLES=1.
module tb_cache_arbiter;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_read, mem_write, busy, last_grant;
  logic [31:0] rdata0, rdata1, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] mem_addr;

  logic        b_req1 = 0;
  logic        b_ack0, b_ack1, b_mem_read, b_mem_write, b_busy, b_last;
  logic [31:0] b_rdata0, b_rdata1, b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'h5a5a1234;
  logic [15:0] b_mem_addr;

  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(16), .DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .last_grant(last_grant));

  cache_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(16), .DATA_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req0(1'b0), .req1(b_req1), .we0(1'b0), .we1(1'b0),
    .addr0(16'h0000), .addr1(16'h0042), .wdata0(32'h0), .wdata1(32'h0),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .last_grant(b_last));

  // Emulated mem_cache: strobes are stable for a whole cycle, so sample them mid-cycle.
  logic [31:0] cmem [logic [15:0]];
  initial forever begin
    @(negedge clk);
    if (mem_write) cmem[mem_addr] = mem_wdata;
    mem_rdata = cmem.exists(mem_addr) ? cmem[mem_addr] : 32'h0;
  end

  // Transaction-level reference state
  logic [31:0] ref_mem [logic [15:0]];
  int          m_last = 1;
  logic [31:0] sh_rd0 = '0, sh_rd1 = '0;

  typedef struct {
    logic r0, r1, w0, w1;
    logic [15:0] a0, a1;
    logic [31:0] d0, d1;
    int ep;
    logic [31:0] erd;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; b_req1 = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_mem_read", {31'b0, mem_read}, 0);
    chk("rst_mem_write", {31'b0, mem_write}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_acks", {30'b0, ack1, ack0}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_last_grant", {31'b0, last_grant}, 1);
    rst_n = 1'b1;
    sh_rd0 = '0; sh_rd1 = '0; m_last = 1;
  endtask

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic txn(input logic r0, r1, w0, w1, input logic [15:0] a0, a1,
                     input logic [31:0] d0, d1, input int ep, input logic [31:0] erd);
    logic ew; logic [15:0] ea; logic [31:0] ed;
    int strobes = 0, ack_at = -1, ack_port = -1, bad = 0;
    ew = ep ? w1 : w0; ea = ep ? a1 : a0; ed = ep ? d1 : d0;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    for (int i = 1; i <= 40 && ack_at < 0; i++) begin
      @(negedge clk);
      if (mem_read && mem_write) bad++;
      if (ack0 && ack1) bad++;
      if (mem_read || mem_write) begin
        strobes++;
        if (mem_addr !== ea || mem_write !== ew || (ew && mem_wdata !== ed)) bad++;
        addr0 = 16'hffff; addr1 = 16'hffff;
        wdata0 = $urandom; wdata1 = $urandom; we0 = ~w0; we1 = ~w1;
      end
      if (ack0 || ack1) begin
        ack_at = i; ack_port = ack1 ? 1 : 0;
        req0 = 0; req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    if (!ew) begin
      if (ep == 1) sh_rd1 = erd; else sh_rd0 = erd;
    end
    chk("grant", ack_port, ep);
    chk("strobe_cycles", strobes, AC);
    chk("ack_latency", ack_at, AC + 1);
    chk("strobe_integrity", bad, 0);
    chk("rdata0", rdata0, sh_rd0);
    chk("rdata1", rdata1, sh_rd1);
    @(negedge clk);
    chk("busy_after", {31'b0, busy}, 0);
    chk("last_grant", {31'b0, last_grant}, ep);
    m_last = ep;
    if (ew) ref_mem[ea] = ed;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h0000ffff, 32'h0, 0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 32'h00001000, 32'h0, 0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, 32'h0, 32'h0, 0, 32'h00001000};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0002, 32'h0, 32'hdeadbeef, 1, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002, 32'h0, 32'h0, 0, 32'h0000ffff};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002, 32'h0, 32'h0, 1, 32'hdeadbeef};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hffff, 32'h0, 32'h0, 1, 32'h0};

    do_reset();
    foreach (tbl[k])
      txn(tbl[k].r0, tbl[k].r1, tbl[k].w0, tbl[k].w1, tbl[k].a0, tbl[k].a1,
          tbl[k].d0, tbl[k].d1, tbl[k].ep, tbl[k].erd);

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [1:0] pick; logic r0, r1, w0, w1; logic [15:0] a0, a1; logic [31:0] d0, d1;
      int ep;
      pick = 2'($urandom_range(1, 3));
      r0 = pick[0]; r1 = pick[1];
      w0 = 1'($urandom); w1 = 1'($urandom);
      a0 = ($urandom_range(0, 9) == 9) ? 16'hffff : 16'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 9) == 9) ? 16'hffff : 16'($urandom_range(0, 7));
      d0 = $urandom; d1 = $urandom;
      if (r0 && r1) ep = (m_last == 0) ? 1 : 0;
      else          ep = r1 ? 1 : 0;
      txn(r0, r1, w0, w1, a0, a1, d0, d1, ep, ref_read(ep ? a1 : a0));
    end

    // Both ports held continuously: alternating grants, one ack every AC+2 cycles
    do_reset();
    begin
      int ack_t[$]; int ack_p[$];
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0000; addr1 = 16'h0001;
      for (int i = 1; i <= 60 && ack_t.size() < 4; i++) begin
        @(negedge clk);
        if (ack0 || ack1) begin ack_t.push_back(i); ack_p.push_back(ack1 ? 1 : 0); end
      end
      req0 = 0; req1 = 0;
      chk("rr_ack_count", ack_t.size(), 4);
      for (int k = 0; k < ack_t.size(); k++) begin
        chk("rr_order", ack_p[k], k % 2);
        if (k > 0) chk("rr_spacing", ack_t[k] - ack_t[k-1], AC + 2);
      end
      repeat (4) @(negedge clk);
    end

    // Reset during a port 1 read aborts it
    do_reset();
    req1 = 1; we1 = 0; addr1 = 16'h0003;
    @(negedge clk);
    chk("abort_pre_read", {31'b0, mem_read}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_read", {31'b0, mem_read}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    req1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    sh_rd0 = '0; sh_rd1 = '0; m_last = 1;
    begin
      int acks = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (ack1) acks++;
      end
      chk("abort_no_ack1", acks, 0);
      chk("abort_rdata1", rdata1, 0);
    end
    txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002, 32'h0, 32'h0, 0, ref_read(16'h0000));

    // ACCESS_CYCLES=1 instance: period 3 under continuous req1
    b_req1 = 1;
    for (int s = 1; s <= 9; s++) begin
      @(negedge clk);
      chk("ac1_mem_read", {31'b0, b_mem_read}, (s % 3 == 1) ? 1 : 0);
      chk("ac1_ack1", {31'b0, b_ack1}, (s % 3 == 2) ? 1 : 0);
      if (s == 2) chk("ac1_rdata1", b_rdata1, 32'h5a5a1234);
    end
    b_req1 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, number of clk cycles mem_read/mem_write is held per cache access (legal 1..15).
REQ-002 Parameter ADDR_W, default 16, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req0 / req1  input  1  access request from port 0 / port 1, held until matching ack.
REQ-007 we0 / we1  input  1  1 = write, 0 = read, valid with req.
REQ-008 addr0 / addr1  input  ADDR_W  access address, valid with req.
REQ-009 wdata0 / wdata1  input  DATA_W  write data, valid with req.
REQ-010 ack0 / ack1  output  1  one-cycle completion pulse to port 0 / port 1.
REQ-011 rdata0 / rdata1  output  DATA_W  read result for port 0 / port 1, registered.
REQ-012 mem_read / mem_write  output  1  read/write strobes to mem_cache.
REQ-013 mem_addr  output  ADDR_W  address to mem_cache.
REQ-014 mem_wdata  output  DATA_W  write data to mem_cache.
REQ-015 mem_rdata  input  DATA_W  read data from mem_cache.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 last_grant  output  1  index of the most recently completed port.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE, registered, one-hot or binary.
REQ-019 IDLE: at an edge with req0|req1 high, select winner, latch its we/addr/wdata and index, load counter with ACCESS_CYCLES-1, go ACCESS; else stay IDLE.
REQ-020 Arbitration: single requester wins outright; both requesting -> port != last_grant wins (round-robin).
REQ-021 ACCESS: mem_read = ~we_latched, mem_write = we_latched, mem_addr/mem_wdata = latched values, all constant for exactly ACCESS_CYCLES cycles.
REQ-022 ACCESS: counter decrements each edge; at edge with counter == 0 go DONE and, for reads only, capture mem_rdata into rdata of the granted port.
REQ-023 DONE: mem_read = mem_write = 0; ack of granted port high for exactly this one cycle; last_grant <= granted index; next state IDLE.
REQ-024 Latency: request sampled at edge t -> strobes high t..t+ACCESS_CYCLES, ack high t+ACCESS_CYCLES..t+ACCESS_CYCLES+1; minimum issue period ACCESS_CYCLES+2 cycles.
REQ-025 Changes on any req/we/addr/wdata input while not IDLE are ignored; latched values persist.
REQ-026 A requester still holding req when IDLE is re-entered is treated as a new request.
REQ-027 mem_read and mem_write are never both high; both low outside ACCESS.
REQ-028 rdataN holds its value until the next completed read of port N; writes never modify rdata0/rdata1.
REQ-029 ack0 and ack1 are never high in the same cycle.

Reset
REQ-030 rst_n low asynchronously forces state IDLE, counter 0, ack0 = ack1 = 0, mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, rdata0 = rdata1 = 0, busy = 0, last_grant = 1.
REQ-031 Reset mid-ACCESS or mid-DONE aborts the operation: no ack issued, no rdata update; first post-reset tie goes to port 0.

Verification
REQ-032 Port 0 write addr 16'h0000 data 32'h0000ffff, ACCESS_CYCLES=2 -> mem_write high 2 cycles with mem_addr 16'h0000, mem_wdata 32'h0000ffff; ack0 one cycle; rdata0 unchanged (0).
REQ-033 Port 0 write 16'h0001 = 32'h00001000, then port 0 read 16'h0001 -> mem_read high 2 cycles, rdata0 = 32'h00001000 when ack0 high.
REQ-034 req0 and req1 asserted same edge after reset, held continuously -> grant order 0,1,0,1; acks 4 cycles apart alternating ports.
REQ-035 Port 1 read issued, addr1 changed to 16'hffff during ACCESS -> mem_addr stays at original address through ACCESS.
REQ-036 rst_n pulsed low during ACCESS of a port 1 read -> strobes drop immediately, no ack1, rdata1 = 0, busy = 0.
REQ-037 ACCESS_CYCLES=1, single port 1 read -> mem_read high exactly 1 cycle, ack1 one cycle later, period 3 cycles under continuous req1.
